// File: rtl/pic_irq_ack_scheduler_if.sv
// rtl/pic_irq_ack_scheduler_if.sv - CPU-side interrupt request / INTA acknowledge bus
interface pic_irq_ack_scheduler_if #(
   parameter int VEC_HI_W = 5
);
   logic                  inta_neg;
   logic                  int_out;
   logic [VEC_HI_W+2:0]   vector_out;
   logic                  vector_valid;

   modport master (output inta_neg, input int_out, vector_out, vector_valid);
   modport slave  (input inta_neg, output int_out, vector_out, vector_valid);
endinterface

// File: rtl/pic_irq_ack_scheduler.sv
// rtl/pic_irq_ack_scheduler.sv - 8259-style IRR/IMR/ISR priority resolver and two-pulse INTA sequencer
module pic_irq_ack_scheduler #(
   parameter int NUM_IR   = 8,
   parameter int VEC_HI_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_neg,
   input  logic [NUM_IR-1:0]     ir_req,
   input  logic [NUM_IR-1:0]     imr,
   input  logic                  level_trigger,
   input  logic [VEC_HI_W-1:0]   vector_base,
   input  logic                  aeoi,
   input  logic                  rotate_mode,
   input  logic                  cfg_ready,
   input  logic                  eoi_strobe,
   input  logic                  eoi_specific,
   input  logic [2:0]            eoi_level,
   input  logic                  set_prio_strobe,
   input  logic [2:0]            prio_level,
   pic_irq_ack_scheduler_if.slave bus,
   output logic [NUM_IR-1:0]     irr,
   output logic [NUM_IR-1:0]     isr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACK1,
      S_ACK2W,
      S_ACK2
   } state_t;

   state_t                state, state_d;
   logic [NUM_IR-1:0]     ir_q;
   logic [NUM_IR-1:0]     irr_d, isr_d;
   logic [2:0]            lp, lp_d;
   logic [2:0]            sel, sel_d;
   logic                  spur, spur_d;
   logic                  inta_q;
   logic                  int_q, int_d;
   logic                  vvalid_q, vvalid_d;
   logic [VEC_HI_W+2:0]   vec_q, vec_d;

   logic                  fall, rise;
   logic [3:0]            cand_r, top_r;
   logic                  cand_valid, top_valid;
   logic [2:0]            cand, top_isr;
   logic [2:0]            cand_off, top_off;
   logic                  ack_take, aeoi_clr;

   // Scan in priority order lp+1 .. lp; the lowest offset that is set wins.
   function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] low);
      logic [3:0] r;
      logic [2:0] idx;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         idx = low + 3'd1 + 3'(i);
         if (v[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   assign fall = inta_q & ~bus.inta_neg;
   assign rise = ~inta_q & bus.inta_neg;

   assign cand_r     = pick(irr & ~imr, lp);
   assign top_r      = pick(isr, lp);
   assign cand_valid = cand_r[3];
   assign cand       = cand_r[2:0];
   assign top_valid  = top_r[3];
   assign top_isr    = top_r[2:0];
   assign cand_off   = cand - lp - 3'd1;
   assign top_off    = top_isr - lp - 3'd1;

   assign bus.int_out      = int_q;
   assign bus.vector_out   = vec_q;
   assign bus.vector_valid = vvalid_q;

   always_comb begin
      state_d  = state;
      sel_d    = sel;
      spur_d   = spur;
      isr_d    = isr;
      lp_d     = lp;
      vec_d    = vec_q;
      vvalid_d = vvalid_q;
      int_d    = 1'b0;
      ack_take = 1'b0;
      aeoi_clr = 1'b0;
      irr_d    = level_trigger ? ir_req : (irr | (ir_req & ~ir_q));

      case (state)
         S_IDLE: begin
            if (fall) begin
               state_d = S_ACK1;
               if (cand_valid) begin
                  sel_d    = cand;
                  spur_d   = 1'b0;
                  ack_take = 1'b1;
               end else begin
                  sel_d  = 3'd7;
                  spur_d = 1'b1;
               end
            end else begin
               int_d = cand_valid && (!top_valid || (cand_off < top_off));
            end
         end
         S_ACK1: begin
            if (rise) state_d = S_ACK2W;
         end
         S_ACK2W: begin
            if (fall) begin
               state_d  = S_ACK2;
               vec_d    = {vector_base, sel};
               vvalid_d = 1'b1;
            end
         end
         S_ACK2: begin
            if (rise) begin
               state_d  = S_IDLE;
               vvalid_d = 1'b0;
               aeoi_clr = aeoi && !spur;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (eoi_strobe) begin
         if (eoi_specific) begin
            isr_d[eoi_level] = 1'b0;
         end else if (top_valid) begin
            isr_d[top_isr] = 1'b0;
            if (rotate_mode) lp_d = top_isr;
         end
      end

      if (aeoi_clr) begin
         isr_d[sel] = 1'b0;
         if (rotate_mode) lp_d = sel;
      end

      // Acknowledge capture is applied last so it overrides any same-cycle EOI or request set.
      if (ack_take) begin
         isr_d[cand] = 1'b1;
         irr_d[cand] = 1'b0;
      end

      if (set_prio_strobe) lp_d = prio_level;

      if (!cfg_ready) begin
         state_d  = S_IDLE;
         irr_d    = '0;
         isr_d    = '0;
         lp_d     = 3'd7;
         sel_d    = 3'd0;
         spur_d   = 1'b0;
         int_d    = 1'b0;
         vvalid_d = 1'b0;
         vec_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_neg) begin
      if (!rst_neg) begin
         state    <= S_IDLE;
         ir_q     <= '0;
         inta_q   <= 1'b1;
         irr      <= '0;
         isr      <= '0;
         lp       <= 3'd7;
         sel      <= 3'd0;
         spur     <= 1'b0;
         int_q    <= 1'b0;
         vvalid_q <= 1'b0;
         vec_q    <= '0;
      end else begin
         state    <= state_d;
         ir_q     <= ir_req;
         inta_q   <= bus.inta_neg;
         irr      <= irr_d;
         isr      <= isr_d;
         lp       <= lp_d;
         sel      <= sel_d;
         spur     <= spur_d;
         int_q    <= int_d;
         vvalid_q <= vvalid_d;
         vec_q    <= vec_d;
      end
   end

endmodule
